// File: rtl/multiplier_pkg.sv
// Shared constants for the sequential radix-2 multiplier.
package multiplier_pkg;

    localparam int WIDTH = 32;
    localparam int STEPS = 32;
    localparam int SW    = 6;

    localparam logic [SW-1:0] DONE = SW'(STEPS);
    localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

endpackage

// File: rtl/multiplier_step.sv
// One radix-2 iteration: add or subtract the multiplicand to the
// sign/zero-extended upper half of the partial product, one bit wider
// than an operand so the carry or sign survives the shift.
module mul_step #(
    parameter int WIDTH = multiplier_pkg::WIDTH
) (
    input  logic [WIDTH:0] h,
    input  logic [WIDTH:0] a,
    input  logic           sub,
    output logic [WIDTH:0] sum
);

    // Subtraction applies only to the top multiplier bit in signed mode,
    // where that bit carries a negative weight.
    always_comb begin
        sum = sub ? (h - a) : (h + a);
    end

endmodule

// File: rtl/multiplier.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock,
// 32 stall cycles per product, signed or unsigned operands.
module multiplier #(
    parameter int WIDTH = multiplier_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               u,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               stall,
    output logic [2*WIDTH-1:0] z
);

    import multiplier_pkg::*;

    logic [SW-1:0]      s;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] pCur;
    logic [2*WIDTH-1:0] pNext;
    logic [WIDTH:0]     h;
    logic [WIDTH:0]     a;
    logic [WIDTH:0]     sum;
    logic               sub;

    assign stall = run & (s != DONE);
    assign z     = p;

    // Step 0 works on freshly loaded {0, x} so that all 32 multiplier bits
    // are consumed in 32 cycles; the low half of P holds the remaining
    // multiplier bits and the high half accumulates the product.
    always_comb begin
        pCur  = (s == '0) ? {{WIDTH{1'b0}}, x} : p;
        h     = {u & pCur[2*WIDTH-1], pCur[2*WIDTH-1:WIDTH]};
        a     = pCur[0] ? {u & y[WIDTH-1], y} : '0;
        sub   = u & (s == LAST);
        pNext = p;
        if (s != DONE) begin
            pNext = {sum, pCur[WIDTH-1:1]};
        end
    end

    mul_step #(.WIDTH(WIDTH)) u_step (
        .h   (h),
        .a   (a),
        .sub (sub),
        .sum (sum)
    );

    // Step counter restarts whenever run drops and saturates at DONE;
    // P freezes at DONE so z stays stable while run remains high.
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
            p <= '0;
        end else if (!run) begin
            s <= '0;
        end else begin
            p <= pNext;
            if (s != DONE) begin
                s <= s + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for the sequential multiplier.
module tb_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        u;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [63:0] z;

    int          total = 0;
    int          bad = 0;
    logic [63:0] expQ[$];
    bit          doneSeen = 1'b0;

    multiplier #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .u     (u),
        .x     (x),
        .y     (y),
        .stall (stall),
        .z     (z)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] refMul(input logic su, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = su ? {{32{a[31]}}, a} : {32'b0, a};
        eb = su ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Monitor: counts stall cycles of each run burst and pops the
    // scoreboard when the product is presented.
    initial begin
        int          stallCnt;
        bit          finished;
        logic [63:0] heldExp;
        stallCnt = 0;
        finished = 1'b0;
        heldExp  = '0;
        forever begin
            @(negedge clk);
            if (rst || !run) begin
                stallCnt = 0;
                finished = 1'b0;
            end else if (stall) begin
                if (finished) checkOutput("stall_after_done", {63'b0, stall}, 64'd0);
                else stallCnt++;
            end else if (!finished) begin
                finished = 1'b1;
                doneSeen = 1'b1;
                checkOutput("stall_count", 64'(stallCnt), 64'd32);
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_product actual=%h required=none", z);
                end else begin
                    heldExp = expQ.pop_front();
                    checkOutput("product", z, heldExp);
                end
            end else begin
                checkOutput("hold_z", z, heldExp);
            end
        end
    end

    task automatic waitDone();
        for (int i = 0; i < 80 && !doneSeen; i++) @(posedge clk);
        if (!doneSeen) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout actual=no_done required=done");
        end
    endtask

    task automatic applyStimulus(input logic su, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] expected, input int hold);
        expQ.push_back(expected);
        u        = su;
        x        = a;
        y        = b;
        doneSeen = 1'b0;
        run      = 1'b1;
        waitDone();
        repeat (hold) @(posedge clk);
        #1 run = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        u   = 1'b0;
        x   = '0;
        y   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_z", z, 64'd0);
        checkOutput("reset_stall_idle", {63'b0, stall}, 64'd0);
        run = 1'b1;
        #1;
        checkOutput("reset_stall_run", {63'b0, stall}, 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        run = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 5);
        applyStimulus(1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1);
        applyStimulus(1'b1, 32'd5, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1, 1);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1);
        applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1);
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 0);
        applyStimulus(1'b0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 0);
        applyStimulus(1'b0, 32'd0, 32'h1234, 64'd0, 0);

        // Aborted burst, then a fresh operation
        u = 1'b0;
        x = 32'd9;
        y = 32'd9;
        run = 1'b1;
        repeat (10) @(posedge clk);
        #1 run = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'd7, 32'd6, 64'd42, 0);

        // Reset pulsed at step 20 with run held high
        expQ.push_back(64'h0000_0000_0626_0060);
        u        = 1'b0;
        x        = 32'h1234;
        y        = 32'h5678;
        doneSeen = 1'b0;
        run      = 1'b1;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_z", z, 64'd0);
        checkOutput("midreset_stall", {63'b0, stall}, 64'd1);
        waitDone();
        #1 run = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 150; i++) begin
            logic        ru;
            logic [31:0] rx;
            logic [31:0] ry;
            ru = 1'($urandom_range(0, 1));
            rx = $urandom;
            ry = $urandom;
            applyStimulus(ru, rx, ry, refMul(ru, rx, ry), 0);
        end

        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
